// File: rtl/md_scheduler_pkg.sv
// Shared encodings and types for the HI/LO multiply/divide sequencer.
package md_scheduler_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;
  localparam logic [2:0] MD_RSVD  = 3'd7;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  localparam logic IDLE = 1'b0;
  localparam logic BUSY = 1'b1;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } md_pair_t;

  // True for the multi-cycle ops (mult/multu/div/divu).
  function automatic logic is_md_op(input logic [2:0] op);
    return (op >= MD_MULT) && (op <= MD_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational signed/unsigned multiply and divide producing a HI/LO pair.
module md_arith
  import md_scheduler_pkg::*;
(
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output md_pair_t    result,
  output logic        div_zero
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic               ovf;
  logic        [31:0] b_div;
  logic        [31:0] q_s;
  logic        [31:0] r_s;
  logic        [31:0] q_u;
  logic        [31:0] r_u;

  assign div_zero = (b == 32'd0);
  // MIN_INT / -1 is special-cased so the divider never sees the overflowing pair.
  assign ovf      = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign b_div    = (div_zero || ovf) ? 32'd1 : b;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  assign q_s = ovf ? a     : 32'($signed(a) / $signed(b_div));
  assign r_s = ovf ? 32'd0 : 32'($signed(a) % $signed(b_div));
  assign q_u = a / b_div;
  assign r_u = a % b_div;

  always_comb begin
    result = '0;
    case (md_op)
      MD_MULT:  result = prod_s;
      MD_MULTU: result = prod_u;
      MD_DIV:   result = '{hi: r_s, lo: q_s};
      MD_DIVU:  result = '{hi: r_u, lo: q_u};
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/md_scheduler.sv
// Multi-cycle mult/div sequencer owning HI/LO, with stall request to the hazard unit.
module md_scheduler
  import md_scheduler_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_md_use,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  logic          state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  md_pair_t      pend_q, pend_d;
  logic          pend_dz_q, pend_dz_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;

  md_pair_t arith_res;
  logic     arith_dz;
  logic     start_md;

  md_arith u_md_arith (
    .md_op    (md_op),
    .a        (a),
    .b        (b),
    .result   (arith_res),
    .div_zero (arith_dz)
  );

  assign start_md = start && is_md_op(md_op);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    pend_d    = pend_q;
    pend_dz_d = pend_dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      IDLE: begin
        if (start_md) begin
          state_d   = BUSY;
          count_d   = (md_op == MD_MULT || md_op == MD_MULTU) ? MULT_LOAD : DIV_LOAD;
          pend_d    = arith_res;
          pend_dz_d = (md_op == MD_DIV || md_op == MD_DIVU) && arith_dz;
        end else if (start && md_op == MD_MTHI) begin
          hi_d = a;
        end else if (start && md_op == MD_MTLO) begin
          lo_d = a;
        end
      end
      BUSY: begin
        if (count_q == '0) begin
          state_d = IDLE;
          // Divide by zero keeps the old HI/LO but still honours the busy time.
          if (!pend_dz_q) begin
            hi_d = pend_q.hi;
            lo_d = pend_q.lo;
          end
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      pend_q    <= '0;
      pend_dz_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      pend_q    <= pend_d;
      pend_dz_q <= pend_dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy      = (state_q == BUSY);
  assign stall_req = d_md_use && (busy || start_md);
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_md_scheduler.sv
// Directed table-driven bench for md_scheduler plus reset-abort sequence.
module tb_md_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        d_md_use;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        dmu;
    int          cycles;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[15];
  logic [31:0] prev_hi;
  logic [31:0] prev_lo;

  md_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .md_op     (md_op),
    .a         (a),
    .b         (b),
    .d_md_use  (d_md_use),
    .busy      (busy),
    .stall_req (stall_req),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset && start && busy) begin
      errors++;
      $display("FAIL start_while_busy: start seen while busy=1, required busy=0");
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int n;
    logic is_md;
    is_md = (v.op >= 3'd1) && (v.op <= 3'd4);
    @(negedge clk);
    start = 1'b1; md_op = v.op; a = v.a; b = v.b; d_md_use = v.dmu;
    #1;
    chk("stall_start", idx, 32'(stall_req), 32'(v.dmu & is_md));
    @(negedge clk);
    start = 1'b0; md_op = 3'd0;
    #1;
    n = 0;
    while (busy && n < 40) begin
      chk("stall_busy", idx, 32'(stall_req), 32'(v.dmu));
      chk("hi_hold", idx, hi, prev_hi);
      chk("lo_hold", idx, lo, prev_lo);
      n++;
      @(negedge clk);
      #1;
    end
    chk("busy_len", idx, 32'(n), 32'(v.cycles));
    chk("hi", idx, hi, v.exp_hi);
    chk("lo", idx, lo, v.exp_lo);
    chk("stall_after", idx, 32'(stall_req), 32'd0);
    d_md_use = 1'b0;
    prev_hi = v.exp_hi;
    prev_lo = v.exp_lo;
  endtask

  initial begin
    vecs[0]  = '{3'd1, 32'hFFFF_FFFE, 32'd3,        1'b1, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5,  32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2]  = '{3'd3, 32'hFFFF_FFF9, 32'd2,        1'b0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{3'd4, 32'd7,         32'd2,        1'b1, 10, 32'd1,         32'd3};
    vecs[4]  = '{3'd5, 32'h11,        32'd9,        1'b1, 0,  32'h11,        32'd3};
    vecs[5]  = '{3'd6, 32'h22,        32'd9,        1'b0, 0,  32'h11,        32'h22};
    vecs[6]  = '{3'd3, 32'd5,         32'd0,        1'b1, 10, 32'h11,        32'h22};
    vecs[7]  = '{3'd0, 32'h55,        32'd1,        1'b1, 0,  32'h11,        32'h22};
    vecs[8]  = '{3'd7, 32'h66,        32'd1,        1'b1, 0,  32'h11,        32'h22};
    vecs[9]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 10, 32'd0,         32'h8000_0000};
    vecs[10] = '{3'd3, 32'd7,         32'hFFFF_FFFE, 1'b0, 10, 32'd1,         32'hFFFF_FFFD};
    vecs[11] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0, 5,  32'h4000_0000, 32'd0};
    vecs[12] = '{3'd1, 32'd7,         32'hFFFF_FFFF, 1'b1, 5,  32'hFFFF_FFFF, 32'hFFFF_FFF9};
    vecs[13] = '{3'd4, 32'hFFFF_FFFF, 32'd2,        1'b0, 10, 32'd1,         32'h7FFF_FFFF};
    vecs[14] = '{3'd3, 32'hFFFF_FFF8, 32'd3,        1'b0, 10, 32'hFFFF_FFFE, 32'hFFFF_FFFE};

    reset = 1'b1; start = 1'b0; md_op = 3'd0; a = '0; b = '0; d_md_use = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_hi", 0, hi, 32'd0);
    chk("rst_lo", 0, lo, 32'd0);
    chk("rst_busy", 0, 32'(busy), 32'd0);
    chk("rst_stall", 0, 32'(stall_req), 32'd0);
    prev_hi = '0;
    prev_lo = '0;

    for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

    // Reset during the third busy cycle of a divide discards the result.
    @(negedge clk);
    start = 1'b1; md_op = 3'd3; a = 32'd7; b = 32'd2;
    @(negedge clk);
    start = 1'b0; md_op = 3'd0;
    #1;
    chk("abort_busy1", 0, 32'(busy), 32'd1);
    repeat (2) @(negedge clk);
    #1;
    chk("abort_busy3", 0, 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_busy", 0, 32'(busy), 32'd0);
    chk("abort_hi", 0, hi, 32'd0);
    chk("abort_lo", 0, lo, 32'd0);
    start = 1'b1; md_op = 3'd6; a = 32'h1234;
    @(negedge clk);
    start = 1'b0; md_op = 3'd0;
    #1;
    chk("mtlo_lo", 0, lo, 32'h1234);
    chk("mtlo_hi", 0, hi, 32'd0);
    chk("mtlo_busy", 0, 32'(busy), 32'd0);
    repeat (12) @(negedge clk);
    #1;
    chk("abort_quiet_busy", 0, 32'(busy), 32'd0);
    chk("abort_quiet_lo", 0, lo, 32'h1234);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
